// File: rtl/weight_stream_fetcher_pkg.sv
// rtl/weight_stream_fetcher_pkg.sv - shared types and default widths for the weight stream fetcher
package weight_stream_fetcher_pkg;

  localparam int DEF_ADDR_WIDTH = 20;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 12;
  localparam int CHECKSUM_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/weight_stream_fetcher_if.sv
// rtl/weight_stream_fetcher_if.sv - loader read bus and weight stream bundle
interface weight_stream_fetcher_if
  import weight_stream_fetcher_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_last;
  logic                  w_ready;

  // fetcher side: issues reads, produces the weight stream
  modport master (
    output rd_en, rd_addr, w_valid, w_data, w_last,
    input  rd_data, w_ready
  );

  // environment side: loader plus consumer
  modport slave (
    input  rd_en, rd_addr, w_valid, w_data, w_last,
    output rd_data, w_ready
  );
endinterface

// File: rtl/weight_stream_fetcher_fifo.sv
// rtl/weight_stream_fetcher_fifo.sv - small synchronous FIFO buffering fetched weights
module weight_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rptr];

  // storage array; contents need no reset since empty masks the head
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  // pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/weight_stream_fetcher.sv
// rtl/weight_stream_fetcher.sv - burst reader feeding weights to the conv engine; optional WEIGHT_FETCH_CHECKSUM_EN
module weight_stream_fetcher
  import weight_stream_fetcher_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [CNT_WIDTH-1:0]      count,
  output logic                      busy,
  output logic                      done,
`ifdef WEIGHT_FETCH_CHECKSUM_EN
  output logic [CHECKSUM_WIDTH-1:0] checksum,
`endif
  weight_stream_fetcher_if.master   bus
);
  localparam int PW = $clog2(FIFO_DEPTH) + 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  issued;
  logic                  inflight;
  logic                  inflight_last;
  logic [PW-1:0]         fifo_count;
  logic [PW-1:0]         occupancy;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   head;
  logic                  issue;
  logic                  pop;

  // a read is only issued when its returning word is certain to fit
  assign occupancy = fifo_count + PW'(inflight);
  assign issue     = (state == ST_FETCH) && (issued < cnt_q) && !fifo_full &&
                     (occupancy < PW'(FIFO_DEPTH));

  assign bus.rd_en   = issue;
  assign bus.rd_addr = base + ADDR_WIDTH'(issued);
  assign bus.w_valid = !fifo_empty;
  assign bus.w_data  = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
  assign bus.w_last  = !fifo_empty && head[DATA_WIDTH];
  assign pop         = bus.w_valid && bus.w_ready;

  // control FSM: capture on start, issue reads, wait for the last word to leave
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      base   <= '0;
      cnt_q  <= '0;
      issued <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            base   <= base_addr;
            cnt_q  <= count;
            issued <= '0;
            if (count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= ST_FETCH;
              busy  <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (issue) begin
            issued <= issued + CNT_WIDTH'(1);
            if (issued + CNT_WIDTH'(1) == cnt_q) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && bus.w_last) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // track the single outstanding loader read and whether it is the burst's final word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (issued == cnt_q - CNT_WIDTH'(1));
    end
  end

  weight_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (inflight),
    .wr_data ({inflight_last, bus.rd_data}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef WEIGHT_FETCH_CHECKSUM_EN
  // running sum of accepted words, cleared when a new burst is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (state == ST_IDLE && start) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + CHECKSUM_WIDTH'(bus.w_data);
    end
  end
`endif
endmodule

// File: tb/tb_weight_stream_fetcher.sv
// tb/tb_weight_stream_fetcher.sv - scoreboard bench for weight_stream_fetcher
module tb_weight_stream_fetcher;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [19:0] base_addr;
  logic [11:0] count;
  logic        busy;
  logic        done;
`ifdef WEIGHT_FETCH_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  weight_stream_fetcher_if #(.ADDR_WIDTH(20), .DATA_WIDTH(8)) bus ();

  weight_stream_fetcher #(
    .ADDR_WIDTH (20),
    .DATA_WIDTH (8),
    .CNT_WIDTH  (12),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
`ifdef WEIGHT_FETCH_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [16];

  // loader model: one-cycle registered read, garbage when not strobed
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= rom[bus.rd_addr[3:0]];
    else           bus.rd_data <= 8'hEE;
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_count, word_count, done_count;
  int first_rd, last_rd, first_valid, done_cyc, start_cyc;
  logic [19:0] addr_q [$];
  logic [8:0]  exp_q [$];

  task automatic clear_stats();
    rd_count = 0; word_count = 0; done_count = 0;
    first_rd = -1; last_rd = -1; first_valid = -1; done_cyc = -1;
    addr_q.delete();
    exp_q.delete();
  endtask

  // one clock: scoreboard the current cycle, then move to the next negedge
  task automatic step();
    logic [19:0] ea;
    logic [8:0]  ew;
    #1;
    if (bus.rd_en === 1'b1) begin
      rd_count++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      total++;
      if (addr_q.size() == 0) begin
        bad++;
        $display("FAIL rd_addr_extra got=%h required=none", bus.rd_addr);
      end else begin
        ea = addr_q.pop_front();
        if (bus.rd_addr !== ea) begin
          bad++;
          $display("FAIL rd_addr got=%h required=%h", bus.rd_addr, ea);
        end
      end
    end
    if (bus.w_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    if (bus.w_valid === 1'b1 && bus.w_ready === 1'b1) begin
      word_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL word_extra got=%h required=none", {bus.w_last, bus.w_data});
      end else begin
        ew = exp_q.pop_front();
        if ({bus.w_last, bus.w_data} !== ew) begin
          bad++;
          $display("FAIL word last/data got=%h required=%h", {bus.w_last, bus.w_data}, ew);
        end
      end
    end
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic pulse_start(input logic [19:0] b, input int n, input bit accepted);
    logic [19:0] a;
    start = 1'b1; base_addr = b; count = 12'(n);
    if (accepted) begin
      start_cyc = cyc;
      for (int i = 0; i < n; i++) begin
        a = b + 20'(i);
        addr_q.push_back(a);
        exp_q.push_back({(i == n - 1), rom[a[3:0]]});
      end
    end
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    int d0 = done_count;
    while (done_count == d0 && n < budget) begin step(); n++; end
    total++;
    if (done_count == d0) begin
      bad++;
      $display("FAIL done_timeout got=none required=pulse within %0d", budget);
    end
    step(); step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; bus.w_ready = 1'b0;
    clear_stats();
    step(); step();
    total++;
    if ({busy, done, bus.rd_en, bus.w_valid, bus.w_last} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b required=00000", {busy, done, bus.rd_en, bus.w_valid, bus.w_last});
    end
    total++;
    if (bus.rd_addr !== 20'h0 || bus.w_data !== 8'h0) begin
      bad++;
      $display("FAIL reset_buses got=%h/%h required=0/0", bus.rd_addr, bus.w_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_burst();
    clear_stats();
    bus.w_ready = 1'b1;
    pulse_start(20'h00010, 8, 1'b1);
    run_until_done(40);
    total++;
    if (rd_count != 8 || last_rd - first_rd != 7 || first_rd != start_cyc + 1) begin
      bad++;
      $display("FAIL burst_reads got=%0d span=%0d first=+%0d required=8 span=7 first=+1",
               rd_count, last_rd - first_rd, first_rd - start_cyc);
    end
    total++;
    if (word_count != 8 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL burst_words got=%0d left=%0d required=8 left=0", word_count, exp_q.size());
    end
    total++;
    if (first_valid - start_cyc != 3) begin
      bad++;
      $display("FAIL burst_latency got=%0d required=3", first_valid - start_cyc);
    end
    total++;
    if (done_count != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL burst_done got=%0d busy=%b required=1 busy=0", done_count, busy);
    end
  endtask

  task automatic test_backpressure();
    int  held_bad = 0;
    clear_stats();
    bus.w_ready = 1'b0;
    pulse_start(20'h00100, 10, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.w_valid === 1'b1 && bus.w_data !== exp_q[0][7:0]) held_bad++;
    end
    total++;
    if (rd_count != 4 || bus.rd_en !== 1'b0) begin
      bad++;
      $display("FAIL bp_reads got=%0d rd_en=%b required=4 rd_en=0", rd_count, bus.rd_en);
    end
    total++;
    if (bus.w_valid !== 1'b1 || held_bad != 0 || bus.w_data !== rom[4'h0]) begin
      bad++;
      $display("FAIL bp_hold got=%h valid=%b slips=%0d required=%h valid=1 slips=0",
               bus.w_data, bus.w_valid, held_bad, rom[4'h0]);
    end
    bus.w_ready = 1'b1;
    run_until_done(60);
    total++;
    if (word_count != 10 || rd_count != 10 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_words got=%0d reads=%0d required=10 reads=10", word_count, rd_count);
    end
  endtask

  task automatic test_zero_count();
    clear_stats();
    pulse_start(20'h00200, 0, 1'b1);
    for (int i = 0; i < 4; i++) step();
    total++;
    if (done_count != 1 || done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin
      bad++;
      $display("FAIL zero_done got=%0d at=+%0d required=1 within 2", done_count, done_cyc - start_cyc);
    end
    total++;
    if (rd_count != 0 || first_valid >= 0) begin
      bad++;
      $display("FAIL zero_quiet got=reads %0d valid_at %0d required=reads 0 valid never", rd_count, first_valid);
    end
  endtask

  task automatic test_wrap();
    clear_stats();
    pulse_start(20'hFFFFE, 4, 1'b1);
    run_until_done(30);
    total++;
    if (rd_count != 4 || word_count != 4 || addr_q.size() != 0) begin
      bad++;
      $display("FAIL wrap_count got=%0d/%0d required=4/4", rd_count, word_count);
    end
  endtask

  task automatic test_start_while_busy();
    clear_stats();
    pulse_start(20'h00020, 6, 1'b1);
    step(); step();
    pulse_start(20'h00040, 2, 1'b0);
    run_until_done(40);
    total++;
    if (rd_count != 6 || word_count != 6 || done_count != 1) begin
      bad++;
      $display("FAIL busy_start got=%0d/%0d/%0d required=6/6/1", rd_count, word_count, done_count);
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_stats();
    pulse_start(20'h00030, 10, 1'b1);
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, bus.rd_en, bus.w_valid, bus.w_last} !== 5'b0 ||
        bus.rd_addr !== 20'h0 || bus.w_data !== 8'h0) begin
      bad++;
      $display("FAIL mid_reset got=%b %h %h required=00000 0 0",
               {busy, done, bus.rd_en, bus.w_valid, bus.w_last}, bus.rd_addr, bus.w_data);
    end
    clear_stats();
    @(negedge clk); cyc++;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    total++;
    if (done_count != 0 || rd_count != 0) begin
      bad++;
      $display("FAIL mid_quiet got=done %0d reads %0d required=0 0", done_count, rd_count);
    end
    pulse_start(20'h00050, 3, 1'b1);
    run_until_done(30);
    total++;
    if (word_count != 3 || done_count != 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL mid_restart got=%0d/%0d required=3/1", word_count, done_count);
    end
  endtask

`ifdef WEIGHT_FETCH_CHECKSUM_EN
  task automatic test_checksum();
    clear_stats();
    rom[0] = 8'h01; rom[1] = 8'hFF; rom[2] = 8'h80; rom[3] = 8'h7F;
    pulse_start(20'h00000, 4, 1'b1);
    run_until_done(30);
    total++;
    if (checksum !== 16'h01FF) begin
      bad++;
      $display("FAIL checksum got=%h required=01FF", checksum);
    end
    clear_stats();
    pulse_start(20'h00000, 4, 1'b1);
    total++;
    if (checksum !== 16'h0000) begin
      bad++;
      $display("FAIL checksum_clear got=%h required=0000", checksum);
    end
    run_until_done(30);
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    test_reset();
    test_burst();
    test_backpressure();
    test_zero_count();
    test_wrap();
    test_start_while_busy();
    test_reset_mid_burst();
`ifdef WEIGHT_FETCH_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
